// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction prefetch queue.
// PC_BASE matches the reset vector used by the PC and NPC blocks.
package fetch_queue_pkg;

  localparam logic [31:0] PC_BASE    = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
  localparam int          FQ_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/ring_buf.sv
// Generic ring-buffer storage: one write port, one combinational read port.
// Contents are intentionally left uninitialised on reset.
module ring_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular {pc, instr} prefetch queue between IF and ID.
// Full queue holds the PC via pc_stall; flush empties it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  output logic             push_ready,
  output logic             pc_stall,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [31:0]      pop_pc,
  output logic [31:0]      pop_instr,
  input  logic             flush,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, empty;
  logic             push_fire, pop_fire;
  fq_entry_t        wr_ent, rd_ent;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pc_stall   = push_valid & !push_ready;

  assign push_fire = push_valid & push_ready & !flush;
  assign pop_fire  = pop_valid & pop_ready & !flush;

  assign wr_ent = '{pc: push_pc, instr: push_instr};

  ring_buf #(
    .DEPTH (DEPTH),
    .W     (FQ_ENTRY_W),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_q),
    .wdata (wr_ent),
    .raddr (rd_q),
    .rdata (rd_ent)
  );

  // Empty-state outputs are masked so stale or X storage never leaks to ID.
  assign pop_pc    = empty ? PC_BASE   : rd_ent.pc;
  assign pop_instr = empty ? INSTR_NOP : rd_ent.instr;
  assign count     = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_fire) wr_d = wr_q + 1'b1;
      if (pop_fire)  rd_d = rd_q + 1'b1;
      unique case ({push_fire, pop_fire})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then random traffic.
// Expected entries come from a queue model; a monitor checks every pop.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             push_valid;
  logic [31:0]      push_pc;
  logic [31:0]      push_instr;
  logic             push_ready;
  logic             pc_stall;
  logic             pop_valid;
  logic             pop_ready;
  logic [31:0]      pop_pc;
  logic [31:0]      pop_instr;
  logic             flush;
  logic [PTR_W:0]   count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .push_ready (push_ready),
    .pc_stall   (pc_stall),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .flush      (flush),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t sb[$];
  int   occ = 0;
  int   n_total = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Monitor: every accepted pop must match the oldest modelled entry.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (flush === 1'b1) begin
        sb.delete();
      end else if (pop_valid === 1'b1 && pop_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'(pop_pc), 64'(PC_BASE));
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("pop_pc", 64'(pop_pc), 64'(e.pc));
          chk("pop_instr", 64'(pop_instr), 64'(e.instr));
        end
      end
    end
  end

  task automatic check_outputs(input string tag);
    logic [31:0] epc, eins;
    epc  = (occ > 0) ? sb[0].pc    : PC_BASE;
    eins = (occ > 0) ? sb[0].instr : INSTR_NOP;
    chk({tag, "_count"}, 64'(count), 64'(occ));
    chk({tag, "_pop_valid"}, 64'(pop_valid), 64'(occ > 0));
    chk({tag, "_push_ready"}, 64'(push_ready), 64'(occ < DEPTH));
    chk({tag, "_pc_stall"}, 64'(pc_stall),
        64'(push_valid && occ >= DEPTH));
    chk({tag, "_head_pc"}, 64'(pop_pc), 64'(epc));
    chk({tag, "_head_instr"}, 64'(pop_instr), 64'(eins));
  endtask

  // One clock cycle: drive at negedge, check, update model, wait next negedge.
  task automatic cycle(input string tag, input logic pv, input logic [31:0] pc,
                       input logic pr, input logic fl);
    logic do_push, do_pop;
    ent_t e;
    push_valid = pv;
    push_pc    = pc;
    push_instr = $urandom;
    pop_ready  = pr;
    flush      = fl;
    #1;
    check_outputs(tag);
    do_push = pv && occ < DEPTH && !fl;
    do_pop  = pr && occ > 0 && !fl;
    if (do_push) begin
      e.pc    = pc;
      e.instr = push_instr;
      sb.push_back(e);
    end
    if (fl) occ = 0;
    else    occ = occ + int'(do_push) - int'(do_pop);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    push_valid = 1'b0;
    push_pc    = '0;
    push_instr = '0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs("reset");
    @(negedge clk);

    // Fill to full, then try one more push that must stall.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0);
    cycle("full_stall", 1'b1, 32'h3010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("empty", 1'b0, 32'h0, 1'b1, 1'b0);

    // Steady push+pop at count 2, long enough for both pointers to wrap.
    cycle("pp_pre", 1'b1, 32'h3100, 1'b0, 1'b0);
    cycle("pp_pre", 1'b1, 32'h3104, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("pushpop", 1'b1, 32'h3108 + 32'(4*i), 1'b1, 1'b0);

    // Flush at count 3 with a concurrent push.
    cycle("pre_flush", 1'b1, 32'h3200, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h3999, 1'b0, 1'b1);
    cycle("post_flush", 1'b1, 32'h3040, 1'b0, 1'b0);
    cycle("head_3040", 1'b0, 32'h0, 1'b0, 1'b0);

    // Full with a pop: push rejected, then accepted next cycle.
    for (int i = 0; i < 3; i++) cycle("refill", 1'b1, 32'h3300 + 32'(4*i), 1'b0, 1'b0);
    cycle("full_pop", 1'b1, 32'h3400, 1'b1, 1'b0);
    cycle("retry", 1'b1, 32'h3400, 1'b0, 1'b0);
    cycle("after_retry", 1'b0, 32'h0, 1'b0, 1'b0);

    // Async reset mid-cycle at count 2.
    cycle("to2", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("to2", 1'b0, 32'h0, 1'b1, 1'b0);
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #2;
    chk("pre_async_count", 64'(count), 64'(occ));
    reset = 1'b0;
    #1;
    sb.delete();
    occ = 0;
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    cycle("final", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small circular instruction-prefetch queue between the PC/IM fetch stage and the ID stage of the pipelined MIPS core.
- Each entry is a fetched {pc, instr} pair.
- Decouples fetch from decode stalls and feeds the PC's active-low write-enable (stall) through pc_stall.
- Discards all buffered entries on a control-flow flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (clears on 0 without waiting for clk).
- push_valid  input  1  fetch stage presents a valid pair this cycle.
- push_pc  input  32  byte address of the fetched instruction (0x00003000-based).
- push_instr  input  32  instruction word read from IM.
- push_ready  output  1  queue can accept a push this cycle (= !full).
- pc_stall  output  1  = push_valid & !push_ready; drives the PC write-enable low to hold the PC.
- pop_valid  output  1  head entry valid (= !empty).
- pop_ready  input  1  ID stage consumes the head this cycle (0 while ID is stalled by the hazard unit).
- pop_pc  output  32  head pc; 32'h00003000 when empty.
- pop_instr  output  32  head instr; 32'h00000000 (nop) when empty.
- flush  input  1  branch/jump redirect; discard all entries.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array, plus wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and count register.
- States are implicit in count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- full = (count == DEPTH); empty = (count == 0).
- A push fires when push_valid & push_ready & !flush:
  - writes {push_pc, push_instr} at wr_ptr;
  - wr_ptr increments and wraps DEPTH-1 -> 0.
- A pop fires when pop_valid & pop_ready & !flush; rd_ptr increments and wraps.
- count update rules:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- When FULL, push_ready is 0 and there is no pass-through, even if a pop fires the same cycle. The push is retried next cycle while the PC stays held by pc_stall.
- Push into an EMPTY queue: no bypass. pop_valid rises on the next edge, so fetch-to-decode latency is 1 cycle.
- Pop from EMPTY is ignored, since pop_valid = 0.
- pop_pc and pop_instr are combinational reads at rd_ptr, forced to the constants 32'h00003000 / 0 when empty.
- Flush has priority over push and pop in the same cycle:
  - on the next edge wr_ptr = rd_ptr = 0 and count = 0;
  - a concurrent push is dropped (fetch re-issues from the redirect target).
- Reset (reset == 0, asynchronous, any cycle including mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0;
  - so pop_valid = 0, push_ready = 1, pc_stall = 0, pop_pc = 32'h00003000, pop_instr = 0;
  - array contents are not cleared;
  - after release, the first push needs a rising edge with reset == 1.
- No alignment checking; push_pc is stored as given.
- Outputs never show X after reset: empty-state outputs are masked to the constants above.

Decomposition:
- Shared package constants:
  - PC_BASE = 32'h00003000 (shared with the PC and NPC blocks);
  - INSTR_NOP = 32'h00000000;
  - FQ_ENTRY_W = 64.
- No sub-module required. Pointer increment and wrap are inline.
- Entry storage may be split into a generic ring-buffer sub-module named ring_buf if another queue reuses it.

Test Plan:
- Reset: hold reset = 0 for 3 cycles, then release -> count = 0, pop_valid = 0, push_ready = 1, pop_pc = 32'h00003000, pop_instr = 0.
- Fill and drain: push pcs 0x3000, 0x3004, 0x3008, 0x300C with pop_ready = 0 -> count = 4, push_ready = 0, pc_stall = 1 while push_valid = 1. Then pop_ready = 1 for 4 cycles -> pop_pc sequence 0x3000..0x300C, then empty.
- Simultaneous push and pop at count = 2 -> count stays 2, FIFO order preserved. Run for 8 cycles so both pointers wrap.
- Flush with push_valid = 1 at count = 3 -> next cycle count = 0, pop_valid = 0, pushed pc not present. Then push 0x3040 -> it is the head one cycle later.
- Full plus pop in the same cycle with push_valid = 1 -> pop occurs, push is rejected (count = 3). Push accepted next cycle (count = 4).
- Asynchronous reset asserted mid-cycle at count = 2 -> pop_valid drops immediately without a clk edge.
